fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter TAM_POSICIONES, 1024, number of instruction ROM words.
REQ-002 SHALL have parameter TAM_PALABRA, 32, instruction width in bits.
REQ-003 SHALL have parameter RESET_VECTOR, 32'h0000_0000, byte address of the first fetch.
REQ-004 SHALL have ports:
  CLK  input  1  single clock, all state on rising edge.
  RST  input  1  asynchronous, active-high reset.
  START  input  1  leave IDLE and begin fetching.
  STALL  input  1  hold PC and IF/ID register.
  REDIRECT  input  1  taken branch/jump, flush and load target.
  TARGET  input  32  redirect byte address.
  INSTRUCTION_IN  input  TAM_PALABRA  instruction word from the ROM.
  INS_ADDRESS  output  $clog2(TAM_POSICIONES)  ROM word address.
  READ_EN  output  1  ROM read enable.
  IFID_PC  output  32  PC of the latched instruction.
  IFID_INSTR  output  TAM_PALABRA  latched instruction.
  IFID_VALID  output  1  IFID_INSTR is a real instruction.
  HALTED  output  1  unit is in HALT.
  FAULT  output  2  00 none, 01 misaligned target, 10 PC out of ROM range.
  FETCH_COUNT  output  32  number of instructions latched valid.
REQ-005 SHALL use one clock; reset is asynchronous and active-high (CLK, RST).

Function
REQ-006 SHALL hold a 32-bit byte PC; INS_ADDRESS SHALL equal PC[$clog2(TAM_POSICIONES)+1:2], combinationally.
REQ-007 SHALL drive READ_EN = 1 only in state FETCH, combinationally; 0 in IDLE and HALT.
REQ-008 SHALL implement FSM IDLE, FETCH, HALT; IDLE->FETCH on START=1; FETCH->HALT on EBREAK, fault or range end; HALT is left only by RST.
REQ-009 Per-edge priority in FETCH SHALL be: REDIRECT > STALL > normal fetch; START is ignored outside IDLE.
REQ-010 Normal fetch: IFID_PC<=PC, IFID_INSTR<=INSTRUCTION_IN, IFID_VALID<=1, PC<=PC+4, FETCH_COUNT+=1; latency ROM-address to IFID output = 1 cycle.
REQ-011 STALL=1 (no REDIRECT): PC, IFID_*, FETCH_COUNT SHALL hold; READ_EN stays 1.
REQ-012 REDIRECT=1 with TARGET[1:0]==00 and TARGET < 4*TAM_POSICIONES: PC<=TARGET, IFID_INSTR<=32'h0000_0013 (NOP), IFID_VALID<=0, even if STALL=1.
REQ-013 REDIRECT=1 with TARGET[1:0]!=00: FAULT<=01, state<=HALT, IFID flushed as REQ-012, PC unchanged.
REQ-014 REDIRECT=1 with aligned TARGET >= 4*TAM_POSICIONES: FAULT<=10, state<=HALT, IFID flushed, PC unchanged.
REQ-015 Normal fetch of INSTRUCTION_IN==32'h0010_0073 (EBREAK): instruction SHALL be latched valid and counted, PC<=PC+4, state<=HALT, FAULT stays 00.
REQ-016 Normal fetch at the last ROM word (PC==4*TAM_POSICIONES-4): word latched valid and counted, PC<=PC+4 (no wrap), state<=HALT, FAULT<=10.
REQ-017 In HALT and IDLE: PC, IFID_*, FAULT, FETCH_COUNT SHALL hold; HALTED=1 only in HALT.
REQ-018 FETCH_COUNT SHALL saturate at 32'hFFFF_FFFF, never wrap.
REQ-019 STALL and REDIRECT in IDLE or HALT SHALL have no effect.

Reset
REQ-020 RST=1 SHALL immediately, without CLK, set: state IDLE, PC=RESET_VECTOR, IFID_PC=0, IFID_INSTR=32'h0000_0013, IFID_VALID=0, FAULT=00, FETCH_COUNT=0, HALTED=0, hence READ_EN=0.
REQ-021 RST asserted mid-fetch, mid-stall or in HALT SHALL abort with the REQ-020 values; first fetch after release needs START.

Verification
REQ-022 Reset, START, ROM = 0x00500093, 0x00100113, 0x00100073 -> IFID_PC 0,4,8 on consecutive cycles, VALID=1, then HALTED=1, FAULT=00, FETCH_COUNT=3, PC=12.
REQ-023 STALL high 3 cycles at PC=8 -> INS_ADDRESS=2 and IFID held 3 cycles, FETCH_COUNT unchanged, resumes at IFID_PC=8.
REQ-024 REDIRECT with TARGET=0x40 while STALL=1 -> next edge IFID_INSTR=0x00000013, VALID=0, INS_ADDRESS=16; following edge IFID_PC=0x40.
REQ-025 REDIRECT TARGET=0x42 -> HALTED=1, FAULT=01, READ_EN=0; REDIRECT TARGET=0x1000 (1024 words) -> FAULT=10.
REQ-026 Straight-line code to PC=0xFFC -> word 1023 latched valid, then HALTED=1, FAULT=10, READ_EN=0.
REQ-027 RST pulse between edges mid-fetch -> outputs at REQ-020 values before next CLK edge; START ignored while RST=1.

Source files
------------

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : single-issue instruction fetch stage with IF/ID register
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter int          TAM_POSICIONES = 1024,
  parameter int          TAM_PALABRA    = 32,
  parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              START,
  input  logic                              STALL,
  input  logic                              REDIRECT,
  input  logic [31:0]                       TARGET,
  input  logic [TAM_PALABRA-1:0]            INSTRUCTION_IN,
  output logic [$clog2(TAM_POSICIONES)-1:0] INS_ADDRESS,
  output logic                              READ_EN,
  output logic [31:0]                       IFID_PC,
  output logic [TAM_PALABRA-1:0]            IFID_INSTR,
  output logic                              IFID_VALID,
  output logic                              HALTED,
  output logic [1:0]                        FAULT,
  output logic [31:0]                       FETCH_COUNT
);

  localparam int                     c_AW        = $clog2(TAM_POSICIONES);
  localparam logic [32:0]            c_ROM_BYTES = 33'(4 * TAM_POSICIONES);
  localparam logic [31:0]            c_LAST_PC   = 32'(4 * TAM_POSICIONES - 4);
  localparam logic [TAM_PALABRA-1:0] c_NOP       = TAM_PALABRA'(32'h0000_0013);
  localparam logic [TAM_PALABRA-1:0] c_EBREAK    = TAM_PALABRA'(32'h0010_0073);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  localparam logic [1:0] c_FAULT_NONE  = 2'b00;
  localparam logic [1:0] c_FAULT_ALIGN = 2'b01;
  localparam logic [1:0] c_FAULT_RANGE = 2'b10;

  logic [1:0]             r_state;
  logic [1:0]             w_state_next;
  logic [31:0]            r_pc;
  logic [31:0]            r_ifid_pc;
  logic [TAM_PALABRA-1:0] r_ifid_instr;
  logic                   r_ifid_valid;
  logic [1:0]             r_fault;
  logic [31:0]            r_fetch_count;

  logic w_tgt_misaligned;
  logic w_tgt_out_of_range;
  logic w_is_ebreak;
  logic w_last_word;

  assign w_tgt_misaligned   = |TARGET[1:0];
  assign w_tgt_out_of_range = ({1'b0, TARGET} >= c_ROM_BYTES);
  assign w_is_ebreak        = (INSTRUCTION_IN == c_EBREAK);
  // >= rather than == so a reset vector beyond the ROM also stops the unit
  assign w_last_word        = (r_pc >= c_LAST_PC);

  assign INS_ADDRESS = r_pc[c_AW+1:2];
  assign IFID_PC     = r_ifid_pc;
  assign IFID_INSTR  = r_ifid_instr;
  assign IFID_VALID  = r_ifid_valid;
  assign FAULT       = r_fault;
  assign FETCH_COUNT = r_fetch_count;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        if (REDIRECT) begin
          if (w_tgt_misaligned || w_tgt_out_of_range) begin
            w_state_next = S_HALT;
          end
        end else if (!STALL) begin
          if (w_is_ebreak || w_last_word) begin
            w_state_next = S_HALT;
          end
        end
      end
      S_HALT:  w_state_next = S_HALT;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    READ_EN = 1'b0;
    HALTED  = 1'b0;
    case (r_state)
      S_FETCH: READ_EN = 1'b1;
      S_HALT:  HALTED  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pc          <= RESET_VECTOR;
      r_ifid_pc     <= 32'h0000_0000;
      r_ifid_instr  <= c_NOP;
      r_ifid_valid  <= 1'b0;
      r_fault       <= c_FAULT_NONE;
      r_fetch_count <= 32'h0000_0000;
    end else if (r_state == S_FETCH) begin
      if (REDIRECT) begin
        r_ifid_instr <= c_NOP;
        r_ifid_valid <= 1'b0;
        if (w_tgt_misaligned) begin
          r_fault <= c_FAULT_ALIGN;
        end else if (w_tgt_out_of_range) begin
          r_fault <= c_FAULT_RANGE;
        end else begin
          r_pc <= TARGET;
        end
      end else if (!STALL) begin
        r_ifid_pc    <= r_pc;
        r_ifid_instr <= INSTRUCTION_IN;
        r_ifid_valid <= 1'b1;
        r_pc         <= r_pc + 32'd4;
        if (r_fetch_count != 32'hFFFF_FFFF) begin
          r_fetch_count <= r_fetch_count + 32'd1;
        end
        // Running off the ROM end is a fault even when the last word is EBREAK
        if (w_last_word) begin
          r_fault <= c_FAULT_RANGE;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit : directed self-checking bench for fetch_unit
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  logic        CLK;
  logic        RST;
  logic        START;
  logic        STALL;
  logic        REDIRECT;
  logic [31:0] TARGET;
  logic [31:0] INSTRUCTION_IN;
  logic [9:0]  INS_ADDRESS;
  logic        READ_EN;
  logic [31:0] IFID_PC;
  logic [31:0] IFID_INSTR;
  logic        IFID_VALID;
  logic        HALTED;
  logic [1:0]  FAULT;
  logic [31:0] FETCH_COUNT;

  logic [31:0] rom [0:1023];
  int          n_checks;
  int          n_fail;

  fetch_unit #(
    .TAM_POSICIONES (1024),
    .TAM_PALABRA    (32),
    .RESET_VECTOR   (32'h0000_0000)
  ) u_dut (
    .CLK            (CLK),
    .RST            (RST),
    .START          (START),
    .STALL          (STALL),
    .REDIRECT       (REDIRECT),
    .TARGET         (TARGET),
    .INSTRUCTION_IN (INSTRUCTION_IN),
    .INS_ADDRESS    (INS_ADDRESS),
    .READ_EN        (READ_EN),
    .IFID_PC        (IFID_PC),
    .IFID_INSTR     (IFID_INSTR),
    .IFID_VALID     (IFID_VALID),
    .HALTED         (HALTED),
    .FAULT          (FAULT),
    .FETCH_COUNT    (FETCH_COUNT)
  );

  assign INSTRUCTION_IN = rom[INS_ADDRESS];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_read_en"}, 32'(READ_EN), 32'd0);
    check({tag, "_halted"},  32'(HALTED), 32'd0);
    check({tag, "_addr"},    32'(INS_ADDRESS), 32'd0);
    check({tag, "_ifid_pc"}, IFID_PC, 32'd0);
    check({tag, "_instr"},   IFID_INSTR, 32'h0000_0013);
    check({tag, "_valid"},   32'(IFID_VALID), 32'd0);
    check({tag, "_fault"},   32'(FAULT), 32'd0);
    check({tag, "_count"},   FETCH_COUNT, 32'd0);
  endtask

  task automatic apply_reset();
    START    = 1'b0;
    STALL    = 1'b0;
    REDIRECT = 1'b0;
    TARGET   = 32'd0;
    RST      = 1'b1;
    #1;
    check_reset_values("rst");
    #1;
    RST = 1'b0;
  endtask

  task automatic start_fetch();
    START = 1'b1;
    tick();
    START = 1'b0;
    check("start_read_en", 32'(READ_EN), 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 1024; i++) rom[i] = 32'h0000_0013;
    rom[0]    = 32'h0050_0093;
    rom[1]    = 32'h0010_0113;
    rom[2]    = 32'h0010_0073;
    rom[1022] = 32'h1111_1111;
    rom[1023] = 32'h2222_2222;
    RST = 1'b0;
    START = 1'b0;
    STALL = 1'b0;
    REDIRECT = 1'b0;
    TARGET = 32'd0;
    tick();

    // Three-instruction program ending in EBREAK
    apply_reset();
    tick();
    check("idle_read_en", 32'(READ_EN), 32'd0);
    start_fetch();
    check("f0_valid_pre", 32'(IFID_VALID), 32'd0);
    tick();
    check("f0_pc", IFID_PC, 32'h0);
    check("f0_instr", IFID_INSTR, 32'h0050_0093);
    check("f0_valid", 32'(IFID_VALID), 32'd1);
    tick();
    check("f1_pc", IFID_PC, 32'h4);
    check("f1_instr", IFID_INSTR, 32'h0010_0113);
    tick();
    check("f2_pc", IFID_PC, 32'h8);
    check("f2_instr", IFID_INSTR, 32'h0010_0073);
    check("eb_halted", 32'(HALTED), 32'd1);
    check("eb_fault", 32'(FAULT), 32'd0);
    check("eb_count", FETCH_COUNT, 32'd3);
    check("eb_addr", 32'(INS_ADDRESS), 32'd3);
    check("eb_read_en", 32'(READ_EN), 32'd0);
    STALL = 1'b1;
    REDIRECT = 1'b1;
    TARGET = 32'h40;
    tick();
    check("halt_hold_addr", 32'(INS_ADDRESS), 32'd3);
    check("halt_hold_count", FETCH_COUNT, 32'd3);
    check("halt_hold_valid", 32'(IFID_VALID), 32'd1);

    // Stall at PC=8, then redirect under stall
    rom[2] = 32'h0000_0013;
    apply_reset();
    start_fetch();
    tick();
    tick();
    check("pre_stall_addr", 32'(INS_ADDRESS), 32'd2);
    STALL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_addr", 32'(INS_ADDRESS), 32'd2);
      check("stall_ifid_pc", IFID_PC, 32'h4);
      check("stall_count", FETCH_COUNT, 32'd2);
      check("stall_read_en", 32'(READ_EN), 32'd1);
    end
    STALL = 1'b0;
    tick();
    check("resume_ifid_pc", IFID_PC, 32'h8);
    check("resume_count", FETCH_COUNT, 32'd3);
    STALL = 1'b1;
    REDIRECT = 1'b1;
    TARGET = 32'h40;
    tick();
    check("redir_instr", IFID_INSTR, 32'h0000_0013);
    check("redir_valid", 32'(IFID_VALID), 32'd0);
    check("redir_addr", 32'(INS_ADDRESS), 32'd16);
    check("redir_count", FETCH_COUNT, 32'd3);
    STALL = 1'b0;
    REDIRECT = 1'b0;
    tick();
    check("redir_ifid_pc", IFID_PC, 32'h40);
    check("redir_valid2", 32'(IFID_VALID), 32'd1);

    // Misaligned redirect target
    REDIRECT = 1'b1;
    TARGET = 32'h42;
    tick();
    REDIRECT = 1'b0;
    check("mis_halted", 32'(HALTED), 32'd1);
    check("mis_fault", 32'(FAULT), 32'd1);
    check("mis_read_en", 32'(READ_EN), 32'd0);
    check("mis_addr", 32'(INS_ADDRESS), 32'd17);
    check("mis_valid", 32'(IFID_VALID), 32'd0);

    // Redirect target past the ROM
    apply_reset();
    start_fetch();
    REDIRECT = 1'b1;
    TARGET = 32'h1000;
    tick();
    REDIRECT = 1'b0;
    check("oor_halted", 32'(HALTED), 32'd1);
    check("oor_fault", 32'(FAULT), 32'd2);
    check("oor_addr", 32'(INS_ADDRESS), 32'd0);

    // Fetch through the last ROM word
    apply_reset();
    start_fetch();
    REDIRECT = 1'b1;
    TARGET = 32'hFF8;
    tick();
    REDIRECT = 1'b0;
    check("end_addr", 32'(INS_ADDRESS), 32'd1022);
    tick();
    check("end_w1022_pc", IFID_PC, 32'hFF8);
    check("end_w1022_halted", 32'(HALTED), 32'd0);
    tick();
    check("end_w1023_pc", IFID_PC, 32'hFFC);
    check("end_w1023_instr", IFID_INSTR, 32'h2222_2222);
    check("end_w1023_valid", 32'(IFID_VALID), 32'd1);
    check("end_halted", 32'(HALTED), 32'd1);
    check("end_fault", 32'(FAULT), 32'd2);
    check("end_read_en", 32'(READ_EN), 32'd0);
    check("end_count", FETCH_COUNT, 32'd2);

    // Asynchronous reset between edges, START held during reset
    apply_reset();
    start_fetch();
    tick();
    tick();
    check("mid_count", FETCH_COUNT, 32'd2);
    START = 1'b1;
    RST = 1'b1;
    #1;
    check_reset_values("async");
    @(posedge CLK);
    #1;
    check("rst_start_read_en", 32'(READ_EN), 32'd0);
    check("rst_start_count", FETCH_COUNT, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    START = 1'b0;
    tick();
    check("post_rst_idle", 32'(READ_EN), 32'd0);
    check("post_rst_addr", 32'(INS_ADDRESS), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
